// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: PC, synchronous-read memory client, show-ahead prefetch FIFO.
// Optional FETCH_PERF_CNT_EN adds fetchCount/stallCount performance counters.
module ins_fetch_unit #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic                  halt,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectAddr,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memWriteEn,
    input  logic [WIDTH-1:0]      memDataIn,
    output logic                  insValid,
    input  logic                  insReady,
    output logic [WIDTH-1:0]      insData,
    output logic [ADDR_WIDTH-1:0] insAddr,
    output logic                  busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetchCount,
    output logic [31:0]           stallCount
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W:0]        OCC_MAX = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } entry_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  tag_v_q, tag_v_d;
    logic [ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    entry_t                fifo_q [FIFO_DEPTH];
    entry_t                fifo_d [FIFO_DEPTH];
    logic [WIDTH-1:0]      ins_data_q, ins_data_d;
    logic [ADDR_WIDTH-1:0] ins_addr_q, ins_addr_d;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        occupancy;
    entry_t                push_entry;

    // State register
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; halt wins over start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && !halt) state_d = RUN;
            RUN:     if (halt)           state_d = HALTED;
            HALTED:  if (start && !halt) state_d = RUN;
            default:                     state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        occupancy = {1'b0, count_q} + (CNT_W + 1)'(tag_v_q);
        issue     = (state_q == RUN) && !halt && !redirect && (occupancy < OCC_MAX);
        busy      = (state_q == RUN) || (count_q != '0) || tag_v_q;
    end

    // Datapath: PC, return-tag stage, FIFO and registered head
    always_comb begin
        pop        = (count_q != '0) && insReady;
        push       = tag_v_q && !redirect;
        push_entry = '{addr: tag_addr_q, data: memDataIn};

        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirectAddr;
        end else if ((state_q == IDLE) && (state_d == RUN)) begin
            pc_d = startAddr;
        end else if (issue) begin
            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + ADDR_WIDTH'(1);
        end

        tag_v_d    = issue;
        tag_addr_d = issue ? pc_q : tag_addr_q;

        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ins_data_d = ins_data_q;
        ins_addr_d = ins_addr_q;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = push_entry;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            // Head register bypasses the array when the pushed entry becomes head at once
            if (count_d != '0) begin
                if (count_q == CNT_W'(pop)) begin
                    ins_data_d = push_entry.data;
                    ins_addr_d = push_entry.addr;
                end else begin
                    ins_data_d = fifo_q[rd_ptr_d].data;
                    ins_addr_d = fifo_q[rd_ptr_d].addr;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            pc_q       <= '0;
            tag_v_q    <= 1'b0;
            tag_addr_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_q     <= '{default: '0};
            ins_data_q <= '0;
            ins_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_v_q    <= tag_v_d;
            tag_addr_q <= tag_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_q     <= fifo_d;
            ins_data_q <= ins_data_d;
            ins_addr_q <= ins_addr_d;
        end
    end

    assign memAddress = pc_q;
    assign memWriteEn = 1'b0;
    assign insValid   = (count_q != '0);
    assign insData    = ins_data_q;
    assign insAddr    = ins_addr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        stall_cnt_d = stall_cnt_q + 32'(insValid && !insReady);
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign stallCount = stall_cnt_q;
`endif

    a_no_push_when_full: assert property (@(posedge clock) disable iff (!resetN)
        !(push && !pop && (count_q == CNT_FULL)));

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Scoreboard bench for ins_fetch_unit with a registered-read instruction memory model.
module tb_ins_fetch_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int FD    = 4;

    logic            clock = 1'b0;
    logic            resetN;
    logic            start;
    logic [AW-1:0]   startAddr;
    logic            halt;
    logic            redirect;
    logic [AW-1:0]   redirectAddr;
    logic [AW-1:0]   memAddress;
    logic            memWriteEn;
    logic [WIDTH-1:0] memDataIn = '0;
    logic            insValid;
    logic            insReady;
    logic [WIDTH-1:0] insData;
    logic [AW-1:0]   insAddr;
    logic            busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     fetchCount;
    logic [31:0]     stallCount;
`endif

    always #5 clock = ~clock;

    ins_fetch_unit #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .start        (start),
        .startAddr    (startAddr),
        .halt         (halt),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .memAddress   (memAddress),
        .memWriteEn   (memWriteEn),
        .memDataIn    (memDataIn),
        .insValid     (insValid),
        .insReady     (insReady),
        .insData      (insData),
        .insAddr      (insAddr),
        .busy         (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount   (fetchCount),
        .stallCount   (stallCount)
`endif
    );

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clock) memDataIn <= mem[memAddress];

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pops  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every accepted instruction must be the next one of the expected sequence
    always @(negedge clock) begin
        if (resetN && insValid && insReady) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_pop", {24'd0, insAddr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check_eq("ins_addr", {24'd0, insAddr}, {24'd0, mon_e.addr});
                check_eq("ins_data", {24'd0, insData}, {24'd0, mon_e.data});
            end
            n_pops++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_seq(input logic [AW-1:0] first, input int n);
        logic [AW-1:0] a;
        a = first;
        sb.delete();
        n_pops = 0;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{addr: a, data: mem[a]});
            a = a + 8'd1;
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        sb.delete();
        n_pops = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a);
        startAddr = a;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k;
        k = 0;
        while (n_pops < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        check_eq("pop_wait", 32'(n_pops >= target), 32'd1);
    endtask

    task automatic halt_and_drain();
        int k;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        k = 0;
        @(negedge clock);
        while (busy && k < 30) begin
            @(negedge clock);
            k++;
        end
        check_eq("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] held;
        int            lat;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0]   s0;
`endif
        resetN = 1'b0; start = 1'b0; startAddr = '0; halt = 1'b0;
        redirect = 1'b0; redirectAddr = '0; insReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 7 + 3) ^ 8'h5A);
        mem[8'h10] = 8'hDA; mem[8'h11] = 8'h33; mem[8'h12] = 8'h5A; mem[8'h13] = 8'hA5;
        mem[8'h80] = 8'h77;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;

        repeat (3) tick();
        check_eq("rst_memAddress", {24'd0, memAddress}, 32'd0);
        check_eq("rst_insValid",   {31'd0, insValid}, 32'd0);
        check_eq("rst_busy",       {31'd0, busy}, 32'd0);
        check_eq("rst_insData",    {24'd0, insData}, 32'd0);
        check_eq("rst_insAddr",    {24'd0, insAddr}, 32'd0);
        check_eq("memWriteEn",     {31'd0, memWriteEn}, 32'd0);
        resetN = 1'b1;
        tick();

        // Basic stream from 0x10 with the core always ready
        load_seq(8'h10, 32);
        insReady = 1'b1;
        pulse_start(8'h10);
        lat = 0;
        @(negedge clock);
        while (!insValid && lat < 10) begin
            lat++;
            @(negedge clock);
        end
        check_eq("start_latency", 32'(lat), 32'd2);
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            check_eq("stream_valid", {31'd0, insValid}, 32'd1);
        end
        tick();
        halt_and_drain();
        check_eq("halt_pc_next", {24'd0, memAddress}, 32'(8'h10 + n_pops));
`ifdef FETCH_PERF_CNT_EN
        check_eq("fetchCount", fetchCount, 32'(n_pops));
`endif

        // Core stalled: FIFO fills and the PC stops at 0x14
        do_reset();
        load_seq(8'h10, 32);
        insReady = 1'b0;
        pulse_start(8'h10);
        repeat (8) tick();
        check_eq("stall_memAddress", {24'd0, memAddress}, 32'h14);
        check_eq("stall_insValid",   {31'd0, insValid}, 32'd1);
        check_eq("stall_insData",    {24'd0, insData}, 32'hDA);
        check_eq("stall_insAddr",    {24'd0, insAddr}, 32'h10);
        check_eq("stall_busy",       {31'd0, busy}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        s0 = stallCount;
        repeat (3) tick();
        check_eq("stallCount_delta", stallCount - s0, 32'd3);
`endif

        // One pop leaves three entries, then redirect to 0x80
        insReady = 1'b1;
        tick();
        insReady = 1'b0;
        check_eq("pre_redir_valid", {31'd0, insValid}, 32'd1);
        redirect = 1'b1;
        redirectAddr = 8'h80;
        tick();
        redirect = 1'b0;
        load_seq(8'h80, 32);
        insReady = 1'b1;
        @(negedge clock);
        check_eq("redir_gap0", {31'd0, insValid}, 32'd0);
        @(negedge clock);
        check_eq("redir_gap1", {31'd0, insValid}, 32'd0);
        @(negedge clock);
        check_eq("redir_resume", {31'd0, insValid}, 32'd1);
        wait_pops(4, 20);
        tick();
        halt_and_drain();

        // PC wrap at the top of memory
        do_reset();
        load_seq(8'hFE, 16);
        insReady = 1'b1;
        pulse_start(8'hFE);
        wait_pops(3, 20);
        tick();
        halt_and_drain();

        // Halt after two pops, drain, then resume from the held PC
        do_reset();
        load_seq(8'h40, 64);
        insReady = 1'b1;
        pulse_start(8'h40);
        wait_pops(2, 20);
        halt_and_drain();
        check_eq("halt_insValid", {31'd0, insValid}, 32'd0);
        held = memAddress;
        repeat (3) tick();
        check_eq("halt_frozen", {24'd0, memAddress}, {24'd0, held});
        check_eq("halt_held_pc", {24'd0, memAddress}, 32'(8'h40 + n_pops));
        pulse_start(8'h00);
        wait_pops(n_pops + 6, 30);
        tick();
        halt_and_drain();
        check_eq("resume_pc", {24'd0, memAddress}, 32'(8'h40 + n_pops));

        // Reset in the middle of a stream
        do_reset();
        load_seq(8'h20, 32);
        insReady = 1'b1;
        pulse_start(8'h20);
        wait_pops(3, 20);
        tick();
        resetN = 1'b0;
        tick();
        check_eq("midrst_insValid",   {31'd0, insValid}, 32'd0);
        check_eq("midrst_busy",       {31'd0, busy}, 32'd0);
        check_eq("midrst_memAddress", {24'd0, memAddress}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("midrst_fetchCount", fetchCount, 32'd0);
`endif
        resetN = 1'b1;
        sb.delete();
        repeat (4) tick();
        check_eq("midrst_idle_pc",   {24'd0, memAddress}, 32'd0);
        check_eq("midrst_idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
